// File: rtl/coder_pkg.sv
// ============================================================================
//  Module      : coder_pkg
//  Description : Shared code-word type, serializer state encoding and helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package coder_pkg;

    localparam int CODE_WIDTH = 4;

    typedef logic [CODE_WIDTH-1:0] code_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/code_fifo.sv
// ============================================================================
//  Module      : code_fifo
//  Description : DEPTH-entry synchronous FIFO holding code words for the
//                serializer; combinational read of the head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_fifo
    import coder_pkg::*;
#(
    parameter int WIDTH = CODE_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_addr_w = addr_bits(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign full   = (r_count == c_full_cnt);
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rd_ptr];

    // A push while full is refused even when a pop frees a slot this cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/code_serializer.sv
// ============================================================================
//  Module      : code_serializer
//  Description : Buffers parallel code words and shifts them out MSB first,
//                back-to-back with no bubble between consecutive words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_serializer
    import coder_pkg::*;
#(
    parameter int WIDTH = CODE_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_last,
    output logic             busy
);

    localparam int c_cnt_w = addr_bits(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    ser_state_t         r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_full;
    logic               w_empty;
    logic [WIDTH-1:0]   w_dout;
    logic               w_push;
    logic               w_pop;
    logic               w_shifting;
    logic               w_last;

    code_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_in),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign ready_out  = !w_full && !rst;
    assign w_push     = valid_in && ready_out;
    assign w_shifting = (r_state == S_SHIFT);
    assign w_last     = w_shifting && (r_cnt == c_last_bit);

    // Pop only from a registered non-empty FIFO, so a fresh push never bypasses.
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || w_last);

    assign ser_valid  = w_shifting;
    assign ser_out    = w_shifting && r_shift[WIDTH-1];
    assign frame_last = w_last;
    assign busy       = w_shifting || !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_dout;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (!w_empty) begin
                            r_shift <= w_dout;
                        end else begin
                            r_shift <= '0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_shift <= r_shift << 1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_shift <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_code_serializer.sv
// ============================================================================
//  Module      : tb_code_serializer
//  Description : Self-checking bench for code_serializer (model + literals).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_code_serializer;
    import coder_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             ready_out;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_last;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    code_serializer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .frame_last (frame_last),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word queue plus the word currently on the wire and
    // the number of its bits still to be sent.
    code_t mq[$];
    code_t m_word   = '0;
    int    m_bits   = 0;
    bit    model_on = 1'b0;

    always @(posedge clk) begin : m_upd
        int old_size;
        if (rst) begin
            mq.delete();
            m_bits   = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            old_size = mq.size();
            if (m_bits <= 1) begin
                if (old_size > 0) begin
                    m_word = mq.pop_front();
                    m_bits = WIDTH;
                end else begin
                    m_bits = 0;
                end
            end else begin
                m_bits = m_bits - 1;
            end
            if (valid_in && old_size < DEPTH) begin
                mq.push_back(data_in);
            end
        end
    end

    always @(negedge clk) begin : m_cmp
        logic e_valid, e_out, e_last, e_busy, e_ready;
        if (model_on) begin
            e_valid = (m_bits > 0);
            e_out   = (m_bits > 0) ? m_word[m_bits-1] : 1'b0;
            e_last  = (m_bits == 1);
            e_busy  = (m_bits > 0) || (mq.size() > 0);
            e_ready = !rst && (mq.size() < DEPTH);
            check("model_ser_valid",  16'(ser_valid),  16'(e_valid));
            check("model_ser_out",    16'(ser_out),    16'(e_out));
            check("model_frame_last", 16'(frame_last), 16'(e_last));
            check("model_busy",       16'(busy),       16'(e_busy));
            check("model_ready_out",  16'(ready_out),  16'(e_ready));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds valid_in/data_in until a handshake edge; returns just after it.
    task automatic push_word(input code_t w);
        bit done;
        done     = 1'b0;
        valid_in = 1'b1;
        data_in  = w;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = ready_out;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no handshake expected handshake for %b", w);
        end
    endtask

    logic [15:0] c_bits;
    logic [15:0] c_lasts;
    int          c_span;

    task automatic collect(input int n);
        int got, guard, first;
        got   = 0;
        guard = 0;
        first = 0;
        c_bits  = '0;
        c_lasts = '0;
        c_span  = 0;
        while (got < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (ser_valid) begin
                if (got == 0) first = guard;
                c_bits  = {c_bits[14:0], ser_out};
                c_lasts = {c_lasts[14:0], frame_last};
                got++;
                c_span = guard - first + 1;
            end
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout: got %0d bits expected %0d", got, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        code_t pat;
        int    junk_cycles;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready",      16'(ready_out),  16'h1);
        check("rst_ser_valid",  16'(ser_valid),  16'h0);
        check("rst_ser_out",    16'(ser_out),    16'h0);
        check("rst_frame_last", 16'(frame_last), 16'h0);
        check("rst_busy",       16'(busy),       16'h0);

        // Single word latency: MSB at k+2, LSB at k+5
        tick();
        valid_in = 1'b1;
        data_in  = 4'b1011;
        tick();
        valid_in = 1'b0;
        data_in  = 4'b0110;
        @(negedge clk);
        check("t1_k1_ser_valid", 16'(ser_valid), 16'h0);
        check("t1_k1_busy",      16'(busy),      16'h1);
        pat = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_bit",        16'(ser_out),    16'(pat[3-i]));
            check("t1_valid",      16'(ser_valid),  16'h1);
            check("t1_frame_last", 16'(frame_last), 16'(i == 3));
        end
        @(negedge clk);
        check("t1_idle_valid", 16'(ser_valid), 16'h0);
        check("t1_idle_busy",  16'(busy),      16'h0);

        // Three back-to-back words, no gap
        tick();
        fork
            begin
                push_word(4'b1011);
                push_word(4'b1010);
                push_word(4'b0011);
                valid_in = 1'b0;
            end
            collect(12);
        join
        check("t2_bits",  c_bits[11:0] & 16'hFFF,  16'b1011_1010_0011);
        check("t2_lasts", c_lasts[11:0] & 16'hFFF, 16'b0001_0001_0001);
        check("t2_span",  16'(c_span),             16'd12);

        // Fill DEPTH=2 FIFO; a fourth word waits for ready_out
        tick();
        tick();
        fork
            begin
                push_word(4'b0110);
                push_word(4'b1100);
                push_word(4'b0101);
                @(negedge clk);
                check("t3_full_ready", 16'(ready_out), 16'h0);
                push_word(4'b1001);
                valid_in = 1'b0;
            end
            collect(16);
        join
        check("t3_bits", c_bits, 16'b0110_1100_0101_1001);

        // Reset in the cycle after the second bit aborts the word
        tick();
        tick();
        push_word(4'b1011);
        valid_in = 1'b0;
        for (int i = 0; i < 20 && !ser_valid; i++) @(negedge clk);
        check("t4_first_bit", 16'(ser_out), 16'h1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t4_valid", 16'(ser_valid), 16'h0);
        check("t4_busy",  16'(busy),      16'h0);
        check("t4_ready", 16'(ready_out), 16'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_no_bits", 16'(ser_valid), 16'h0);
        end

        // Offers while full are refused; only the three real words come out
        tick();
        junk_cycles = 0;
        fork
            begin
                push_word(4'b1110);
                push_word(4'b0001);
                push_word(4'b0111);
                for (int i = 0; i < 8; i++) begin
                    if (!ready_out) begin
                        valid_in = 1'b1;
                        data_in  = 4'(4'hA + i);
                        junk_cycles++;
                    end else begin
                        valid_in = 1'b0;
                        data_in  = 4'hF;
                    end
                    tick();
                end
                valid_in = 1'b0;
            end
            collect(12);
        join
        check("t5_bits", c_bits[11:0] & 16'hFFF, 16'b1110_0001_0111);
        check("t5_junk_offered", 16'(junk_cycles >= 3), 16'h1);

        // data_in toggling with valid_in low is ignored
        for (int i = 0; i < 4; i++) begin
            data_in = 4'(i * 5);
            tick();
        end
        repeat (8) tick();
        @(negedge clk);
        check("t6_ignored_busy", 16'(busy), 16'h0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
